fp_mac_arbiter: RTL and testbench
=================================

// Module: fp_mac_arbiter
// PURPOSE
//  Shares one fp_mac_wrapper instance among NUM_REQ cluster cores. Cores issue operations over a req/gnt handshake.
//  A round-robin arbiter issues one operation per cycle to the MAC, tagged with the requester index.
//  The returning result is steered into a per-requester result buffer, held until that core acknowledges it.
//  Sits between the core-side APU interconnect and the MAC wrapper inside the shared APU.
// PARAMETERS
//  NUM_REQ     4                    number of requesting cores (>=2)
//  RND_WIDTH   NDSFLAGS_MAC         rounding-mode width, forwarded unchanged
//  STAT_WIDTH  NUSFLAGS_MAC         status-flag width, returned unchanged
//  TAG_WIDTH   $clog2(NUM_REQ)      localparam; MAC tag = requester index
// PORTS
//  clk_i         in   1                     clock
//  rst_ni        in   1                     synchronous reset, active-low
//  req_i         in   NUM_REQ               per-core operation request
//  gnt_o         out  NUM_REQ               per-core grant; issue happens when req_i[i] & gnt_o[i]
//  opa_i/opb_i/opc_i in NUM_REQ x FP_WIDTH  per-core operands
//  op_i          in   NUM_REQ x 2           per-core op (sign-flip control for B/C)
//  rnd_i         in   NUM_REQ x RND_WIDTH   per-core rounding mode
//  rvalid_o      out  NUM_REQ               per-core result valid (held until ack)
//  rdata_o       out  NUM_REQ x FP_WIDTH    per-core result
//  rstatus_o     out  NUM_REQ x STAT_WIDTH  per-core status flags
//  rack_i        in   NUM_REQ               per-core result acknowledge
//  mac_en_o      out  1                     MAC enable (one issue)
//  mac_opa_o/mac_opb_o/mac_opc_o out FP_WIDTH  operands to MAC
//  mac_op_o      out  2                     op to MAC
//  mac_rnd_o     out  RND_WIDTH             rounding mode to MAC
//  mac_tag_o     out  TAG_WIDTH             requester index to MAC
//  mac_valid_i   in   1                     MAC result valid
//  mac_res_i     in   FP_WIDTH              MAC result
//  mac_status_i  in   STAT_WIDTH            MAC status
//  mac_tag_i     in   TAG_WIDTH             MAC returned tag
//  err_o         out  1                     sticky: result returned for a non-pending tag
// BEHAVIOUR
//  - Reset (rst_ni=0 at posedge): pending, rvalid, buffers, err_o, rr pointer all 0.
//    All outputs are 0 during and after reset.
//  - eligible[i] = req_i[i] & ~pending[i] & ~rvalid_o[i]; each requester has at most one operation outstanding,
//    so its one-entry result buffer never overflows.
//  - gnt_o is combinational: one-hot among eligible, searched from rr pointer ptr upward with wrap-around; 0 if none eligible.
//  - mac_en_o = |gnt_o, and the mac_* operand/op/rnd/tag outputs are muxed from the winner in the same cycle.
//    When mac_en_o=0, the mac_* data outputs are 0.
//  - Issue to index w: pending[w]<=1 and ptr<=(w+1) mod NUM_REQ. ptr is unchanged when nothing is issued.
//  - Return (mac_valid_i, tag t, pending[t]=1): buffer[t]<=res/status, rvalid_o[t]<=1, pending[t]<=0.
//    The result is visible the cycle after mac_valid_i.
//  - Return with pending[t]=0 or t>=NUM_REQ: dropped, err_o<=1 (sticky until reset).
//  - rack_i[i] & rvalid_o[i]: rvalid_o[i]<=0 next cycle. rack_i without rvalid_o is ignored.
//    A requester may be granted again in the cycle after its ack.
//  - Issue and return in the same cycle for different indices are both processed.
//    A return for index w and an issue to w in the same cycle is impossible by eligibility.
//  - MAC latency is not assumed; results are steered only by tag. Throughput is 1 issue/cycle across requesters.
//  - Reset mid-operation clears all pending and buffers. A late MAC result after reset hits pending=0 and sets err_o;
//    the MAC wrapper is reset by the same rst_ni, so the bench does not expect this.
// CONFIGURATION
//  - FP_MAC_ARB_PERF_EN defined: adds ports perf_clr_i(in,1), perf_issue_o(out,32), perf_conflict_o(out,32).
//    perf_issue_o counts issues; perf_conflict_o counts cycles with >=2 eligible requesters.
//    Both counters wrap at 2^32 and are cleared by reset or perf_clr_i (clear wins over a same-cycle increment).
//  - FP_MAC_ARB_PERF_EN undefined: no ports, no counters; otherwise identical.
// STRUCTURE
//  - apu_cluster_package: FP_WIDTH, NDSFLAGS_MAC, NUSFLAGS_MAC (existing).
//    New typedef fp_mac_req_t {opa, opb, opc, op, rnd} and fp_mac_rsp_t {res, status}.
//  - Sub-module fp_mac_rr_arbiter: NUM_REQ-wide round-robin priority search (eligible, ptr -> one-hot gnt, index).
//  - Top: pending/rvalid flag vectors, result buffers, pointer register, operand mux, perf counters.
// TESTING
//  1 Reset then idle: all outputs 0; assert req_i=4'b0001 with opa=1.0 opb=2.0 opc=0.5 op=0 -> gnt_o=0001 same cycle,
//    mac_tag_o=0; MAC returns 0x40200000 -> rvalid_o[0]=1, rdata_o[0]=2.5 held until rack_i[0].
//  2 req_i=4'b1111 held, ptr=0, MAC model latency 3 -> grants in order 0,1,2,3, one per cycle,
//    then no grants until results are acked.
//  3 Out-of-order model returns tag 2 before tag 0 -> rdata_o[2] and rdata_o[0] each carry their own operands' result.
//  4 Requester 1 never acks -> it is never re-granted while others keep rotating; ack -> granted the next cycle.
//  5 Inject mac_valid_i with tag 3 and no issue to 3 -> err_o=1 sticky, no rvalid_o change; rst_ni=0 one cycle
//    with 2 pending -> pending and rvalid_o cleared, err_o=0.
//  6 FP_MAC_ARB_PERF_EN: 4 requesters x 2 ops -> perf_issue_o=8; perf_conflict_o equals cycles with >=2 eligible;
//    perf_clr_i -> 0 next cycle.

Source files
------------

// File: rtl/fp_mac_arbiter_pkg.sv
// Shared types and widths for the FP MAC sharing logic in the APU cluster.
// Mirrors the FP_WIDTH / NDSFLAGS_MAC / NUSFLAGS_MAC constants of the cluster package.
package fp_mac_arbiter_pkg;

   localparam int FP_WIDTH     = 32;
   localparam int NDSFLAGS_MAC = 3;
   localparam int NUSFLAGS_MAC = 5;

   typedef struct packed {
      logic [FP_WIDTH-1:0]     opa;
      logic [FP_WIDTH-1:0]     opb;
      logic [FP_WIDTH-1:0]     opc;
      logic [1:0]              op;
      logic [NDSFLAGS_MAC-1:0] rnd;
   } fp_mac_req_t;

   typedef struct packed {
      logic [FP_WIDTH-1:0]     res;
      logic [NUSFLAGS_MAC-1:0] status;
   } fp_mac_rsp_t;

endpackage

// File: rtl/fp_mac_rr_arbiter.sv
// Round-robin priority search: first eligible requester at or above ptr, with wrap-around.
// Produces a one-hot grant and the matching index; all zero when nothing is eligible.
module fp_mac_rr_arbiter #(
   parameter  int NUM_REQ   = 4,
   localparam int TAG_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   eligible,
   input  logic [TAG_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [TAG_WIDTH-1:0] idx
);

   int j;

   // Walk offsets from farthest to nearest so the closest eligible one is written last.
   always_comb begin
      gnt = '0;
      idx = '0;
      j   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (eligible[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = TAG_WIDTH'(j);
         end
      end
   end

endmodule

// File: rtl/fp_mac_arbiter.sv
// Shares one FP MAC among NUM_REQ cores: round-robin issue, tag-steered result buffers.
// Optional FP_MAC_ARB_PERF_EN adds issue / conflict counters with a clear input.
module fp_mac_arbiter
   import fp_mac_arbiter_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int RND_WIDTH  = NDSFLAGS_MAC,
   parameter  int STAT_WIDTH = NUSFLAGS_MAC,
   localparam int TAG_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NUM_REQ-1:0]                 req_i,
   output logic [NUM_REQ-1:0]                 gnt_o,
   input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   opa_i,
   input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   opb_i,
   input  logic [NUM_REQ-1:0][FP_WIDTH-1:0]   opc_i,
   input  logic [NUM_REQ-1:0][1:0]            op_i,
   input  logic [NUM_REQ-1:0][RND_WIDTH-1:0]  rnd_i,
   output logic [NUM_REQ-1:0]                 rvalid_o,
   output logic [NUM_REQ-1:0][FP_WIDTH-1:0]   rdata_o,
   output logic [NUM_REQ-1:0][STAT_WIDTH-1:0] rstatus_o,
   input  logic [NUM_REQ-1:0]                 rack_i,
   output logic                               mac_en_o,
   output logic [FP_WIDTH-1:0]                mac_opa_o,
   output logic [FP_WIDTH-1:0]                mac_opb_o,
   output logic [FP_WIDTH-1:0]                mac_opc_o,
   output logic [1:0]                         mac_op_o,
   output logic [RND_WIDTH-1:0]               mac_rnd_o,
   output logic [TAG_WIDTH-1:0]               mac_tag_o,
   input  logic                               mac_valid_i,
   input  logic [FP_WIDTH-1:0]                mac_res_i,
   input  logic [STAT_WIDTH-1:0]              mac_status_i,
   input  logic [TAG_WIDTH-1:0]               mac_tag_i,
   output logic                               err_o
`ifdef FP_MAC_ARB_PERF_EN
   ,
   input  logic                               perf_clr_i,
   output logic [31:0]                        perf_issue_o,
   output logic [31:0]                        perf_conflict_o
`endif
);

   logic [NUM_REQ-1:0]                 pending_q, rvalid_q, eligible, gnt, ret_set;
   logic [NUM_REQ-1:0][FP_WIDTH-1:0]   res_q;
   logic [NUM_REQ-1:0][STAT_WIDTH-1:0] status_q;
   logic [TAG_WIDTH-1:0]               ptr_q, win_idx;
   logic [TAG_WIDTH:0]                 tag_ext;
   logic                               ret_hit, err_q;

   // Gating with rst_ni keeps grants (and therefore mac_en_o) low while in reset.
   assign eligible = req_i & ~pending_q & ~rvalid_q & {NUM_REQ{rst_ni}};

   fp_mac_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .eligible (eligible),
      .ptr      (ptr_q),
      .gnt      (gnt),
      .idx      (win_idx)
   );

   assign gnt_o    = gnt;
   assign mac_en_o = |gnt;

   always_comb begin
      mac_opa_o = '0;
      mac_opb_o = '0;
      mac_opc_o = '0;
      mac_op_o  = '0;
      mac_rnd_o = '0;
      mac_tag_o = '0;
      if (mac_en_o) begin
         mac_opa_o = opa_i[win_idx];
         mac_opb_o = opb_i[win_idx];
         mac_opc_o = opc_i[win_idx];
         mac_op_o  = op_i[win_idx];
         mac_rnd_o = rnd_i[win_idx];
         mac_tag_o = win_idx;
      end
   end

   // A return is accepted only for an in-range tag that is actually outstanding.
   assign tag_ext = {1'b0, mac_tag_i};

   always_comb begin
      ret_set = '0;
      ret_hit = 1'b0;
      if (mac_valid_i && (tag_ext < (TAG_WIDTH+1)'(NUM_REQ))) begin
         if (pending_q[mac_tag_i]) begin
            ret_hit            = 1'b1;
            ret_set[mac_tag_i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending_q <= '0;
         rvalid_q  <= '0;
         res_q     <= '0;
         status_q  <= '0;
         ptr_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= (pending_q | gnt) & ~ret_set;
         rvalid_q  <= (rvalid_q & ~rack_i) | ret_set;
         if (mac_en_o)
            ptr_q <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + TAG_WIDTH'(1);
         if (ret_hit) begin
            res_q[mac_tag_i]    <= mac_res_i;
            status_q[mac_tag_i] <= mac_status_i;
         end
         if (mac_valid_i && !ret_hit) err_q <= 1'b1;
      end
   end

   assign rvalid_o  = rvalid_q;
   assign rdata_o   = res_q;
   assign rstatus_o = status_q;
   assign err_o     = err_q;

`ifdef FP_MAC_ARB_PERF_EN
   logic [31:0] perf_issue_q, perf_conflict_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || perf_clr_i) begin
         perf_issue_q    <= '0;
         perf_conflict_q <= '0;
      end else begin
         if (mac_en_o) perf_issue_q <= perf_issue_q + 32'd1;
         if ($countones(eligible) >= 2) perf_conflict_q <= perf_conflict_q + 32'd1;
      end
   end

   assign perf_issue_o    = perf_issue_q;
   assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_fp_mac_arbiter.sv
// Randomized bench for fp_mac_arbiter with a MAC latency model and a transaction-level reference.
// Define FP_MAC_ARB_PERF_EN on both files to also check the performance counters.
module tb_fp_mac_arbiter;
   import fp_mac_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int TW = 2;
   localparam int RW = NDSFLAGS_MAC;
   localparam int SW = NUSFLAGS_MAC;

   logic                       clk_i = 1'b0;
   logic                       rst_ni = 1'b0;
   logic [N-1:0]               req_i = '0, rack_i = '0;
   logic [N-1:0]               gnt_o, rvalid_o;
   logic [N-1:0][FP_WIDTH-1:0] opa_i = '0, opb_i = '0, opc_i = '0;
   logic [N-1:0][1:0]          op_i = '0;
   logic [N-1:0][RW-1:0]       rnd_i = '0;
   logic [N-1:0][FP_WIDTH-1:0] rdata_o;
   logic [N-1:0][SW-1:0]       rstatus_o;
   logic                       mac_en_o, err_o;
   logic [FP_WIDTH-1:0]        mac_opa_o, mac_opb_o, mac_opc_o;
   logic [1:0]                 mac_op_o;
   logic [RW-1:0]              mac_rnd_o;
   logic [TW-1:0]              mac_tag_o;
   logic                       mac_valid_i = 1'b0;
   logic [FP_WIDTH-1:0]        mac_res_i = '0;
   logic [SW-1:0]              mac_status_i = '0;
   logic [TW-1:0]              mac_tag_i = '0;
`ifdef FP_MAC_ARB_PERF_EN
   logic                       perf_clr_i = 1'b0;
   logic [31:0]                perf_issue_o, perf_conflict_o;
`endif

   fp_mac_arbiter #(.NUM_REQ(N)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
      .opa_i(opa_i), .opb_i(opb_i), .opc_i(opc_i), .op_i(op_i), .rnd_i(rnd_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rstatus_o(rstatus_o), .rack_i(rack_i),
      .mac_en_o(mac_en_o), .mac_opa_o(mac_opa_o), .mac_opb_o(mac_opb_o), .mac_opc_o(mac_opc_o),
      .mac_op_o(mac_op_o), .mac_rnd_o(mac_rnd_o), .mac_tag_o(mac_tag_o),
      .mac_valid_i(mac_valid_i), .mac_res_i(mac_res_i), .mac_status_i(mac_status_i),
      .mac_tag_i(mac_tag_i), .err_o(err_o)
`ifdef FP_MAC_ARB_PERF_EN
      , .perf_clr_i(perf_clr_i), .perf_issue_o(perf_issue_o), .perf_conflict_o(perf_conflict_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Reference state: what each core should see, derived from the arbitration rules.
   logic [N-1:0]               m_pend = '0, m_rv = '0;
   logic [N-1:0][FP_WIDTH-1:0] m_buf = '0, m_exp_res = '0;
   logic [N-1:0][SW-1:0]       m_bst = '0, m_exp_st = '0;
   int  m_ptr = 0, m_iss = 0, m_conf = 0;
   int  m_nissued [N];
   bit  m_err = 1'b0;

   typedef struct {
      int                  tag;
      logic [FP_WIDTH-1:0] res;
      logic [SW-1:0]       st;
      int                  due;
   } mac_ent_t;
   mac_ent_t mac_q [$];
   int  glog [$];
   int  rlog [$];

   int  cyc = 0, lat_min = 3, lat_max = 3;
   bit  ooo = 1'b0, hold_ret = 1'b0, rnd_ops = 1'b0, want_clr = 1'b0;
   int  n_tests = 0, n_fail = 0;

   function automatic logic [FP_WIDTH-1:0] f_res(input logic [FP_WIDTH-1:0] a, b, c,
                                                input logic [1:0] op, input logic [RW-1:0] r);
      return (a ^ {b[15:0], b[31:16]}) + c + {27'd0, op, r};
   endfunction

   function automatic logic [SW-1:0] f_st(input logic [FP_WIDTH-1:0] a, b, c,
                                          input logic [1:0] op, input logic [RW-1:0] r);
      return a[4:0] ^ b[9:5] ^ c[14:10] ^ {op, r};
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic check_regs();
      check("rvalid", 64'(rvalid_o), 64'(m_rv));
      check("err", 64'(err_o), 64'(m_err));
      for (int i = 0; i < N; i++) begin
         if (m_rv[i]) begin
            check($sformatf("rdata%0d", i), 64'(rdata_o[i]), 64'(m_buf[i]));
            check($sformatf("rstatus%0d", i), 64'(rstatus_o[i]), 64'(m_bst[i]));
         end
      end
`ifdef FP_MAC_ARB_PERF_EN
      check("perf_issue", 64'(perf_issue_o), 64'(m_iss));
      check("perf_conflict", 64'(perf_conflict_o), 64'(m_conf));
`endif
   endtask

   task automatic cycle(input logic [N-1:0] rq, input logic [N-1:0] ak, input bit inj,
                        input int inj_tag, input logic [FP_WIDTH-1:0] inj_res);
      logic [N-1:0] elig, exp_gnt;
      int           w, sel, t;
      mac_ent_t     e;
      @(negedge clk_i);
      check_regs();
      req_i  = rq;
      rack_i = ak;
      if (rnd_ops) begin
         for (int i = 0; i < N; i++) begin
            opa_i[i] = $urandom; opb_i[i] = $urandom; opc_i[i] = $urandom;
            op_i[i]  = 2'($urandom); rnd_i[i] = RW'($urandom);
         end
      end
`ifdef FP_MAC_ARB_PERF_EN
      perf_clr_i = want_clr;
`endif
      mac_valid_i  = 1'b0;
      mac_tag_i    = TW'($urandom);
      mac_res_i    = $urandom;
      mac_status_i = SW'($urandom);
      if (inj) begin
         mac_valid_i = 1'b1;
         mac_tag_i   = TW'(inj_tag);
         mac_res_i   = inj_res;
         for (int k = mac_q.size() - 1; k >= 0; k--)
            if (mac_q[k].tag == inj_tag) mac_q.delete(k);
      end else if (!hold_ret) begin
         sel = -1;
         for (int k = 0; k < mac_q.size(); k++)
            if (mac_q[k].due <= cyc && (sel < 0 || (ooo && mac_q[k].tag > mac_q[sel].tag))) sel = k;
         if (sel >= 0) begin
            mac_valid_i  = 1'b1;
            mac_tag_i    = TW'(mac_q[sel].tag);
            mac_res_i    = mac_q[sel].res;
            mac_status_i = mac_q[sel].st;
            rlog.push_back(mac_q[sel].tag);
            mac_q.delete(sel);
         end
      end
      #1;
      elig = rq & ~m_pend & ~m_rv;
      w = -1;
      for (int k = 0; k < N; k++)
         if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      exp_gnt = '0;
      if (w >= 0) exp_gnt[w] = 1'b1;
      check("gnt", 64'(gnt_o), 64'(exp_gnt));
      check("mac_en", 64'(mac_en_o), 64'(w >= 0));
      if (w >= 0) begin
         check("mac_tag", 64'(mac_tag_o), 64'(w));
         check("mac_opa", 64'(mac_opa_o), 64'(opa_i[w]));
         check("mac_opb", 64'(mac_opb_o), 64'(opb_i[w]));
         check("mac_opc", 64'(mac_opc_o), 64'(opc_i[w]));
         check("mac_op_rnd", 64'({mac_op_o, mac_rnd_o}), 64'({op_i[w], rnd_i[w]}));
      end else begin
         check("mac_idle_ops", 64'(mac_opa_o | mac_opb_o | mac_opc_o), 64'd0);
         check("mac_idle_ctl", 64'({mac_op_o, mac_rnd_o, mac_tag_o}), 64'd0);
      end
      // MAC model consumes whatever the DUT actually issued.
      if (mac_en_o) begin
         e.tag = int'(mac_tag_o);
         e.res = f_res(mac_opa_o, mac_opb_o, mac_opc_o, mac_op_o, mac_rnd_o);
         e.st  = f_st(mac_opa_o, mac_opb_o, mac_opc_o, mac_op_o, mac_rnd_o);
         e.due = cyc + int'($urandom_range(lat_max, lat_min));
         mac_q.push_back(e);
         glog.push_back(int'(mac_tag_o));
      end
      m_rv = m_rv & ~ak;
      if (mac_valid_i) begin
         t = int'(mac_tag_i);
         if (m_pend[t]) begin
            m_pend[t] = 1'b0;
            m_rv[t]   = 1'b1;
            m_buf[t]  = inj ? inj_res : m_exp_res[t];
            m_bst[t]  = inj ? mac_status_i : m_exp_st[t];
         end else begin
            m_err = 1'b1;
         end
      end
      if (w >= 0) begin
         m_pend[w]    = 1'b1;
         m_exp_res[w] = f_res(opa_i[w], opb_i[w], opc_i[w], op_i[w], rnd_i[w]);
         m_exp_st[w]  = f_st(opa_i[w], opb_i[w], opc_i[w], op_i[w], rnd_i[w]);
         m_ptr        = (w + 1) % N;
         m_nissued[w]++;
      end
      if (want_clr) begin
         m_iss = 0; m_conf = 0;
      end else begin
         if (w >= 0) m_iss++;
         if ($countones(elig) >= 2) m_conf++;
      end
      cyc++;
   endtask

   task automatic do_reset(input logic [N-1:0] rq);
      @(negedge clk_i);
      rst_ni = 1'b0; req_i = rq; rack_i = '0; mac_valid_i = 1'b0;
      #1;
      check("rst_gnt", 64'(gnt_o), 64'd0);
      check("rst_mac_en", 64'(mac_en_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1; req_i = '0;
      m_pend = '0; m_rv = '0; m_buf = '0; m_bst = '0; m_ptr = 0; m_err = 1'b0;
      m_iss = 0; m_conf = 0; mac_q.delete();
      for (int i = 0; i < N; i++) m_nissued[i] = 0;
      #1;
      check("post_rst_rvalid", 64'(rvalid_o), 64'd0);
      check("post_rst_err", 64'(err_o), 64'd0);
      check("post_rst_rdata", 64'(rdata_o[0] | rdata_o[1] | rdata_o[2] | rdata_o[3]), 64'd0);
      check("post_rst_rstatus", 64'(rstatus_o), 64'd0);
      check("post_rst_mac", 64'({mac_en_o, gnt_o, mac_tag_o}), 64'd0);
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && (mac_q.size() != 0 || m_pend != '0 || m_rv != '0); c++)
         cycle('0, m_rv, 1'b0, 0, '0);
      check("drain_done", 64'(mac_q.size() == 0 && m_pend == '0 && m_rv == '0), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] rq;
      int           n1;
      for (int i = 0; i < N; i++) m_nissued[i] = 0;

      // Reset with all requests up: nothing may be granted.
      do_reset('1);

      // Single operation from core 0, result injected as 2.5.
      opa_i[0] = 32'h3F80_0000; opb_i[0] = 32'h4000_0000; opc_i[0] = 32'h3F00_0000;
      op_i[0] = 2'd0; rnd_i[0] = '0;
      lat_min = 20; lat_max = 20;
      cycle(4'b0001, '0, 1'b0, 0, '0);
      check("t1_gnt", 64'(gnt_o), 64'h1);
      check("t1_tag", 64'(mac_tag_o), 64'h0);
      check("t1_opa", 64'(mac_opa_o), 64'h3F80_0000);
      cycle('0, '0, 1'b1, 0, 32'h4020_0000);
      cycle('0, '0, 1'b0, 0, '0);
      cycle('0, '0, 1'b0, 0, '0);
      check("t1_rvalid", 64'(rvalid_o[0]), 64'd1);
      check("t1_rdata", 64'(rdata_o[0]), 64'h4020_0000);
      cycle('0, 4'b0001, 1'b0, 0, '0);
      cycle('0, '0, 1'b0, 0, '0);
      check("t1_acked", 64'(rvalid_o[0]), 64'd0);

      // All four request, latency 3, no acks: exactly one grant each, in order.
      do_reset('0);
      rnd_ops = 1'b1; lat_min = 3; lat_max = 3;
      glog.delete();
      for (int c = 0; c < 10; c++) cycle('1, '0, 1'b0, 0, '0);
      check("t2_grant_count", 64'(glog.size()), 64'd4);
      for (int k = 0; k < 4; k++)
         check($sformatf("t2_order%0d", k), 64'(k < glog.size() ? glog[k] : -1), 64'(k));
      drain();

      // Out-of-order return: tag 2 comes back before tag 0.
      ooo = 1'b1; hold_ret = 1'b1; lat_min = 1; lat_max = 1;
      rlog.delete();
      cycle(4'b0101, '0, 1'b0, 0, '0);
      cycle(4'b0101, '0, 1'b0, 0, '0);
      cycle('0, '0, 1'b0, 0, '0);
      hold_ret = 1'b0;
      for (int c = 0; c < 3; c++) cycle('0, '0, 1'b0, 0, '0);
      check("t3_first", 64'(rlog.size() > 0 ? rlog[0] : -1), 64'd2);
      check("t3_second", 64'(rlog.size() > 1 ? rlog[1] : -1), 64'd0);
      check("t3_both_valid", 64'(rvalid_o & 4'b0101), 64'h5);
      ooo = 1'b0;
      drain();

      // Core 1 never acks: granted once, others keep rotating; ack re-enables it.
      lat_min = 1; lat_max = 4;
      glog.delete();
      for (int c = 0; c < 40; c++) cycle('1, m_rv & 4'b1101, 1'b0, 0, '0);
      n1 = 0;
      foreach (glog[k]) if (glog[k] == 1) n1++;
      check("t4_grants_to_1", 64'(n1), 64'd1);
      check("t4_others_rotate", 64'((glog.size() - n1) >= 10), 64'd1);
      cycle(4'b0010, 4'b0010, 1'b0, 0, '0);
      cycle(4'b0010, '0, 1'b0, 0, '0);
      check("t4_regrant", 64'(gnt_o), 64'h2);
      drain();

      // Stray return for tag 3 sets sticky err; reset mid-operation clears everything.
      cycle('0, '0, 1'b1, 3, 32'hDEAD_BEEF);
      cycle('0, '0, 1'b0, 0, '0);
      check("t5_err", 64'(err_o), 64'd1);
      check("t5_no_rvalid", 64'(rvalid_o), 64'd0);
      for (int c = 0; c < 3; c++) cycle('0, '0, 1'b0, 0, '0);
      check("t5_sticky", 64'(err_o), 64'd1);
      lat_min = 20; lat_max = 20;
      cycle(4'b0011, '0, 1'b0, 0, '0);
      cycle(4'b0011, '0, 1'b0, 0, '0);
      do_reset('0);
      cycle(4'b0011, '0, 1'b0, 0, '0);
      check("t5_post_rst_gnt", 64'(gnt_o), 64'h1);

      // Random traffic with random acks, latencies, ordering and occasional stray returns.
      do_reset('0);
      lat_min = 1; lat_max = 6;
      for (int c = 0; c < 300; c++) begin
         ooo = 1'($urandom_range(1, 0));
         rq  = N'($urandom);
         if ($urandom_range(49, 0) == 0)
            cycle(rq, N'($urandom), 1'b1, int'($urandom_range(N - 1, 0)), $urandom);
         else
            cycle(rq, N'($urandom), 1'b0, 0, '0);
      end
      ooo = 1'b0;

`ifdef FP_MAC_ARB_PERF_EN
      // Four cores x two operations, then a counter clear.
      do_reset('0);
      lat_min = 1; lat_max = 3;
      for (int c = 0; c < 60 && m_iss < 8; c++) begin
         for (int i = 0; i < N; i++) rq[i] = (m_nissued[i] < 2);
         cycle(rq, m_rv, 1'b0, 0, '0);
      end
      cycle('0, m_rv, 1'b0, 0, '0);
      check("t6_issue", 64'(perf_issue_o), 64'd8);
      check("t6_conflict", 64'(perf_conflict_o), 64'(m_conf));
      want_clr = 1'b1;
      cycle('0, m_rv, 1'b0, 0, '0);
      want_clr = 1'b0;
      cycle('0, m_rv, 1'b0, 0, '0);
      check("t6_clr_issue", 64'(perf_issue_o), 64'd0);
      check("t6_clr_conflict", 64'(perf_conflict_o), 64'd0);
`endif

      drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
